// File: rtl/chip_link_bridge_if.sv
// Bus bundle for chip_link_bridge: NoC router ports, chip-link rx/tx and statistics.
// master = bridge side, slave = router/SerDes side.
interface chip_link_bridge_if #(
   parameter int unsigned FW      = 59,
   parameter int unsigned CONNECT = 2
);
   localparam int unsigned SW = (CONNECT > 1) ? $clog2(CONNECT) : 1;

   logic [CONNECT-1:0]    flit_in_wr_noc;
   logic [FW*CONNECT-1:0] flit_in_noc;
   logic [CONNECT-1:0]    credit_out_noc;
   logic [CONNECT-1:0]    flit_out_wr_noc;
   logic [FW*CONNECT-1:0] flit_out_noc;
   logic [CONNECT-1:0]    credit_in_noc;
   logic                  rx_valid;
   logic [FW+SW-1:0]      rx_data;
   logic                  rx_ready;
   logic                  tx_valid;
   logic [FW+SW-1:0]      tx_data;
   logic                  tx_ready;
   logic [CONNECT-1:0]    connect_available;
   logic [2:0]            err_sticky;
   logic [16*CONNECT-1:0] stat_rx_cnt;
   logic [16*CONNECT-1:0] stat_tx_cnt;

   modport master (
      output flit_in_wr_noc, flit_in_noc, credit_in_noc, rx_ready, tx_valid, tx_data,
             connect_available, err_sticky, stat_rx_cnt, stat_tx_cnt,
      input  credit_out_noc, flit_out_wr_noc, flit_out_noc, rx_valid, rx_data, tx_ready
   );

   modport slave (
      input  flit_in_wr_noc, flit_in_noc, credit_in_noc, rx_ready, tx_valid, tx_data,
             connect_available, err_sticky, stat_rx_cnt, stat_tx_cnt,
      output credit_out_noc, flit_out_wr_noc, flit_out_noc, rx_valid, rx_data, tx_ready
   );
endinterface

// File: rtl/chip_link_bridge.sv
// Chip-link <-> CONNECT NoC bridge with per-channel FIFOs in both directions.
// Optional per-channel flit counters: define CHIP_LINK_STATS_EN.
module chip_link_bridge #(
   parameter int unsigned FW          = 59,
   parameter int unsigned B           = 4,
   parameter int unsigned CONNECT     = 2,
   parameter int unsigned NOC_CREDITS = 15
) (
   input logic                clk,
   input logic                reset,
   chip_link_bridge_if.master bus
);
   localparam int unsigned SW    = (CONNECT > 1) ? $clog2(CONNECT) : 1;
   localparam int unsigned DEPTH = 1 << B;
   localparam int unsigned PW    = B + 1;
   localparam int unsigned CW    = $clog2(NOC_CREDITS + 1);
   localparam int unsigned NTAG  = 1 << SW;

   logic [FW-1:0]      ing_mem [CONNECT][DEPTH];
   logic [PW-1:0]      ing_wr  [CONNECT];
   logic [PW-1:0]      ing_rd  [CONNECT];
   logic [CW-1:0]      credit  [CONNECT];
   logic [CONNECT-1:0] ing_empty, ing_full, ing_push, ing_pop, cred_max;

   logic [FW-1:0]      egr_mem [CONNECT][DEPTH];
   logic [PW-1:0]      egr_wr  [CONNECT];
   logic [PW-1:0]      egr_rd  [CONNECT];
   logic [CONNECT-1:0] egr_empty, egr_full, egr_push, egr_pop;

   logic [NTAG-1:0]    tag_valid, ing_full_pad, egr_req_pad;
   logic [SW-1:0]      rx_tag, gnt_idx, rr_ptr, cand;
   logic               gnt_valid, tx_load, rx_bad, egr_ovf, cred_ovf;
   logic [FW-1:0]      egr_head;

   // FIFO status; tag-indexed vectors are padded to 2^SW so every tag value is addressable
   always_comb begin
      tag_valid    = '0;
      ing_full_pad = '0;
      egr_req_pad  = '0;
      ing_empty    = '0;
      ing_full     = '0;
      egr_empty    = '0;
      egr_full     = '0;
      ing_pop      = '0;
      cred_max     = '0;
      bus.connect_available = '0;
      for (int i = 0; i < CONNECT; i++) begin
         ing_empty[i]    = (ing_wr[i] == ing_rd[i]);
         ing_full[i]     = (PW'(ing_wr[i] - ing_rd[i]) == PW'(DEPTH));
         egr_empty[i]    = (egr_wr[i] == egr_rd[i]);
         egr_full[i]     = (PW'(egr_wr[i] - egr_rd[i]) == PW'(DEPTH));
         ing_pop[i]      = !ing_empty[i] && (credit[i] != '0);
         cred_max[i]     = (credit[i] == CW'(NOC_CREDITS));
         tag_valid[i]    = 1'b1;
         ing_full_pad[i] = ing_full[i];
         egr_req_pad[i]  = !egr_empty[i];
         bus.connect_available[i] = (credit[i] != '0);
      end
   end

   // Ingress demux: out-of-range tags are always accepted and dropped
   assign rx_tag       = bus.rx_data[FW+SW-1:FW];
   assign bus.rx_ready = !tag_valid[rx_tag] || !ing_full_pad[rx_tag];
   assign rx_bad       = bus.rx_valid && !tag_valid[rx_tag];

   always_comb begin
      ing_push = '0;
      cred_ovf = 1'b0;
      for (int i = 0; i < CONNECT; i++) begin
         ing_push[i] = bus.rx_valid && bus.rx_ready && (rx_tag == SW'(i));
         cred_ovf    = cred_ovf || (bus.credit_out_noc[i] && !ing_pop[i] && cred_max[i]);
      end
   end

   // Round-robin grant starting after the last granted channel
   always_comb begin
      tx_load   = !bus.tx_valid || bus.tx_ready;
      gnt_valid = 1'b0;
      gnt_idx   = rr_ptr;
      cand      = '0;
      for (int k = 1; k <= int'(CONNECT); k++) begin
         cand = SW'((int'(rr_ptr) + k) % int'(CONNECT));
         if (!gnt_valid && egr_req_pad[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand;
         end
      end
      egr_pop  = '0;
      egr_push = '0;
      egr_head = '0;
      egr_ovf  = 1'b0;
      for (int i = 0; i < CONNECT; i++) begin
         egr_pop[i]  = tx_load && gnt_valid && (gnt_idx == SW'(i));
         egr_push[i] = bus.flit_out_wr_noc[i] && (!egr_full[i] || egr_pop[i]);
         egr_ovf     = egr_ovf || (bus.flit_out_wr_noc[i] && egr_full[i] && !egr_pop[i]);
         if (gnt_idx == SW'(i)) egr_head = egr_mem[i][egr_rd[i][B-1:0]];
      end
   end

   // FIFO storage, not reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < CONNECT; i++) begin
         if (ing_push[i]) ing_mem[i][ing_wr[i][B-1:0]] <= bus.rx_data[FW-1:0];
         if (egr_push[i]) egr_mem[i][egr_wr[i][B-1:0]] <= bus.flit_out_noc[FW*i +: FW];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CONNECT; i++) begin
            ing_wr[i] <= '0;
            ing_rd[i] <= '0;
            egr_wr[i] <= '0;
            egr_rd[i] <= '0;
            credit[i] <= CW'(NOC_CREDITS);
         end
         rr_ptr             <= '0;
         bus.flit_in_wr_noc <= '0;
         bus.flit_in_noc    <= '0;
         bus.credit_in_noc  <= '0;
         bus.tx_valid       <= 1'b0;
         bus.tx_data        <= '0;
         bus.err_sticky     <= '0;
      end else begin
         for (int i = 0; i < CONNECT; i++) begin
            if (ing_push[i]) ing_wr[i] <= ing_wr[i] + PW'(1);
            if (egr_push[i]) egr_wr[i] <= egr_wr[i] + PW'(1);
            if (egr_pop[i])  egr_rd[i] <= egr_rd[i] + PW'(1);
            if (ing_pop[i]) begin
               ing_rd[i] <= ing_rd[i] + PW'(1);
               bus.flit_in_noc[FW*i +: FW] <= ing_mem[i][ing_rd[i][B-1:0]];
            end
            if (ing_pop[i] && !bus.credit_out_noc[i])
               credit[i] <= credit[i] - CW'(1);
            else if (!ing_pop[i] && bus.credit_out_noc[i] && !cred_max[i])
               credit[i] <= credit[i] + CW'(1);
         end
         bus.flit_in_wr_noc <= ing_pop;
         bus.credit_in_noc  <= egr_pop;
         if (tx_load) begin
            bus.tx_valid <= gnt_valid;
            if (gnt_valid) begin
               bus.tx_data <= {gnt_idx, egr_head};
               rr_ptr      <= gnt_idx;
            end
         end
         bus.err_sticky <= bus.err_sticky | {cred_ovf, egr_ovf, rx_bad};
      end
   end

`ifdef CHIP_LINK_STATS_EN
   // Saturating per-channel counters of issued / transmitted flits
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.stat_rx_cnt <= '0;
         bus.stat_tx_cnt <= '0;
      end else begin
         for (int i = 0; i < CONNECT; i++) begin
            if (ing_pop[i] && (bus.stat_rx_cnt[16*i +: 16] != 16'hFFFF))
               bus.stat_rx_cnt[16*i +: 16] <= bus.stat_rx_cnt[16*i +: 16] + 16'd1;
            if (egr_pop[i] && (bus.stat_tx_cnt[16*i +: 16] != 16'hFFFF))
               bus.stat_tx_cnt[16*i +: 16] <= bus.stat_tx_cnt[16*i +: 16] + 16'd1;
         end
      end
   end
`else
   assign bus.stat_rx_cnt = '0;
   assign bus.stat_tx_cnt = '0;
`endif

endmodule

// File: tb/tb_chip_link_bridge.sv
// Randomized bench for chip_link_bridge against a queue-based reference model.
module tb_chip_link_bridge;
   localparam int FW    = 24;
   localparam int B     = 4;
   localparam int NCH   = 3;
   localparam int NCRED = 15;
   localparam int SW    = 2;
   localparam int DW    = FW + SW;
   localparam int DEPTH = 1 << B;

   logic clk;
   logic reset;

   chip_link_bridge_if #(.FW(FW), .CONNECT(NCH)) bus ();

   chip_link_bridge #(.FW(FW), .B(B), .CONNECT(NCH), .NOC_CREDITS(NCRED)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   logic [FW-1:0]  iq [NCH][$];
   logic [FW-1:0]  eq [NCH][$];
   int             cr [NCH];
   logic [FW-1:0]  m_fin [NCH];
   logic [NCH-1:0] m_wr, m_cin;
   logic           m_txv;
   logic [DW-1:0]  m_txd;
   int             m_ptr;
   logic [2:0]     m_err;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         iq[i].delete();
         eq[i].delete();
         cr[i]    = NCRED;
         m_fin[i] = '0;
      end
      m_wr  = '0;
      m_cin = '0;
      m_txv = 1'b0;
      m_txd = '0;
      m_ptr = 0;
      m_err = '0;
   endtask

   function automatic logic exp_rx_ready();
      int t;
      t = int'(bus.rx_data[FW+SW-1:FW]);
      if (t >= NCH) return 1'b1;
      return iq[t].size() < DEPTH;
   endfunction

   // Advance the model by one clock edge using the inputs held across it
   task automatic model_edge();
      int pre_i [NCH];
      int pre_e [NCH];
      int g;
      int c;
      int t;
      if (reset) begin
         model_reset();
         return;
      end
      for (int i = 0; i < NCH; i++) begin
         pre_i[i] = iq[i].size();
         pre_e[i] = eq[i].size();
      end
      for (int i = 0; i < NCH; i++) begin
         m_wr[i] = (pre_i[i] > 0) && (cr[i] > 0);
         if (m_wr[i]) m_fin[i] = iq[i].pop_front();
         if (bus.credit_out_noc[i]) begin
            if (!m_wr[i]) begin
               if (cr[i] == NCRED) m_err[2] = 1'b1;
               else cr[i]++;
            end
         end else if (m_wr[i]) begin
            cr[i]--;
         end
      end
      t = int'(bus.rx_data[FW+SW-1:FW]);
      if (bus.rx_valid) begin
         if (t >= NCH) m_err[0] = 1'b1;
         else if (pre_i[t] < DEPTH) iq[t].push_back(bus.rx_data[FW-1:0]);
      end
      m_cin = '0;
      g = -1;
      if (!m_txv || bus.tx_ready) begin
         for (int k = 1; k <= NCH; k++) begin
            c = (m_ptr + k) % NCH;
            if (g < 0 && pre_e[c] > 0) g = c;
         end
         if (g >= 0) begin
            m_txd    = {SW'(g), eq[g].pop_front()};
            m_txv    = 1'b1;
            m_cin[g] = 1'b1;
            m_ptr    = g;
         end else begin
            m_txv = 1'b0;
         end
      end
      for (int i = 0; i < NCH; i++) begin
         if (bus.flit_out_wr_noc[i]) begin
            if (pre_e[i] < DEPTH || i == g) eq[i].push_back(bus.flit_out_noc[FW*i +: FW]);
            else m_err[1] = 1'b1;
         end
      end
   endtask

   task automatic compare_outputs();
      logic [NCH-1:0] avail;
      for (int i = 0; i < NCH; i++) avail[i] = (cr[i] > 0);
      check("flit_in_wr_noc", 64'(bus.flit_in_wr_noc), 64'(m_wr));
      for (int i = 0; i < NCH; i++)
         if (m_wr[i]) check($sformatf("flit_in_noc[%0d]", i), 64'(bus.flit_in_noc[FW*i +: FW]), 64'(m_fin[i]));
      check("credit_in_noc", 64'(bus.credit_in_noc), 64'(m_cin));
      check("tx_valid", 64'(bus.tx_valid), 64'(m_txv));
      if (m_txv) check("tx_data", 64'(bus.tx_data), 64'(m_txd));
      check("connect_available", 64'(bus.connect_available), 64'(avail));
      check("err_sticky", 64'(bus.err_sticky), 64'(m_err));
   endtask

   // Called with inputs set while clk is low; returns at the following negedge
   task automatic cycle();
      #1;
      if (!reset) check("rx_ready", 64'(bus.rx_ready), 64'(exp_rx_ready()));
      @(posedge clk);
      model_edge();
      #1;
      compare_outputs();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.rx_valid        = 1'b0;
      bus.rx_data         = '0;
      bus.credit_out_noc  = '0;
      bus.flit_out_wr_noc = '0;
      bus.flit_out_noc    = '0;
      bus.tx_ready        = 1'b1;
   endtask

   int wr1_cnt;
   int cred_pct;

   initial begin
      reset = 1'b1;
      idle_inputs();
      model_reset();
      for (int n = 0; n < 3; n++) cycle();
      reset = 1'b0;
      check("reset_tx_data", 64'(bus.tx_data), 64'(0));
      check("reset_flit_in_noc", 64'(bus.flit_in_noc), 64'(0));
      check("reset_avail", 64'(bus.connect_available), 64'(3'b111));

      // 16 flits on ch1 with no credits returned
      wr1_cnt = 0;
      for (int n = 0; n < 30; n++) begin
         bus.rx_valid = (n < 16);
         bus.rx_data  = {2'd1, FW'($urandom())};
         cycle();
         wr1_cnt += int'(bus.flit_in_wr_noc[1]);
      end
      bus.rx_valid = 1'b0;
      check("ch1_pulses_15", 64'(wr1_cnt), 64'(15));
      check("ch1_avail_zero", 64'(bus.connect_available[1]), 64'(0));
      bus.credit_out_noc = 3'b010;
      cycle();
      bus.credit_out_noc = '0;
      for (int n = 0; n < 4; n++) begin
         cycle();
         wr1_cnt += int'(bus.flit_in_wr_noc[1]);
      end
      check("ch1_release", 64'(wr1_cnt), 64'(16));

      // out-of-range tag is accepted and dropped
      bus.rx_valid = 1'b1;
      bus.rx_data  = {2'd3, FW'($urandom())};
      cycle();
      bus.rx_valid = 1'b0;
      cycle();
      check("bad_tag_err", 64'(bus.err_sticky), 64'(3'b001));

      // simultaneous router writes on all channels
      bus.flit_out_wr_noc = 3'b111;
      bus.flit_out_noc    = {FW'($urandom()), FW'($urandom()), FW'($urandom())};
      cycle();
      bus.flit_out_wr_noc = '0;
      for (int n = 0; n < 6; n++) cycle();

      // stall tx and overfill ch0 egress
      bus.flit_out_wr_noc = 3'b001;
      bus.flit_out_noc    = {2*FW'(0), FW'($urandom())};
      cycle();
      bus.flit_out_wr_noc = '0;
      cycle();
      bus.tx_ready = 1'b0;
      for (int n = 0; n < 17; n++) begin
         bus.flit_out_wr_noc = 3'b001;
         bus.flit_out_noc    = {2*FW'(0), FW'($urandom())};
         cycle();
      end
      bus.flit_out_wr_noc = '0;
      cycle();
      check("egr_ovf_err", 64'(bus.err_sticky[1]), 64'(1));

      // reset with ch0 egress full
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("rst_tx_valid", 64'(bus.tx_valid), 64'(0));
      check("rst_credit_in", 64'(bus.credit_in_noc), 64'(0));
      check("rst_avail", 64'(bus.connect_available), 64'(3'b111));
      bus.tx_ready = 1'b1;
      for (int n = 0; n < 4; n++) cycle();

      // randomized traffic with varying credit-return rate
      for (int n = 0; n < 3000; n++) begin
         if (n % 250 == 0) cred_pct = int'($urandom_range(5, 60));
         bus.rx_valid = ($urandom_range(0, 3) != 0);
         bus.rx_data  = {(($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2))), FW'($urandom())};
         for (int i = 0; i < NCH; i++) begin
            bus.credit_out_noc[i]  = (int'($urandom_range(0, 99)) < cred_pct);
            bus.flit_out_wr_noc[i] = ($urandom_range(0, 2) == 0);
         end
         bus.flit_out_noc = {FW'($urandom()), FW'($urandom()), FW'($urandom())};
         bus.tx_ready     = ($urandom_range(0, 3) != 0);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
